// File: rtl/testbasic0_reader_pkg.sv
// rtl/testbasic0_reader_pkg.sv - shared section encoding and parameter defaults for testbasic0_reader
package testbasic0_reader_types;

   typedef enum logic [1:0] {
      SEC_IDLE = 2'd0,
      SEC_BUSY = 2'd1,
      SEC_FULL = 2'd2
   } Sections;

   localparam int DEFAULT_DATA_W = 32;
   localparam int DEFAULT_DEPTH  = 4;

endpackage

// File: rtl/testbasic0_reader_fifo.sv
// rtl/testbasic0_reader_fifo.sv - storage, pointers and occupancy for the reader FIFO
// Exposes next-cycle occupancy and next head word so the top can register its outputs.
module testbasic0_reader_fifo
   import testbasic0_reader_types::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W,
   parameter int DEPTH  = DEFAULT_DEPTH,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int OCC_W = PTR_W + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] din,
   output logic [OCC_W-1:0]  occ_next,
   output logic [DATA_W-1:0] head_next
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr_next;
   logic [PTR_W-1:0]  wr_ptr_next;
   logic [OCC_W-1:0]  occ;

   always_comb begin
      rd_ptr_next = pop  ? rd_ptr + PTR_W'(1) : rd_ptr;
      wr_ptr_next = push ? wr_ptr + PTR_W'(1) : wr_ptr;
      case ({push, pop})
         2'b10:   occ_next = occ + OCC_W'(1);
         2'b01:   occ_next = occ - OCC_W'(1);
         default: occ_next = occ;
      endcase
      // The word being written this cycle may already be the next head.
      if (push && (wr_ptr == rd_ptr_next))
         head_next = din;
      else
         head_next = mem[rd_ptr_next];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         occ    <= '0;
      end else begin
         if (push)
            mem[wr_ptr] <= din;
         rd_ptr <= rd_ptr_next;
         wr_ptr <= wr_ptr_next;
         occ    <= occ_next;
      end
   end

endmodule

// File: rtl/testbasic0_reader.sv
// rtl/testbasic0_reader.sv - elastic reader stage for the blocking sync/notify port protocol
// Optional running sum output enabled by TESTBASIC0_READER_SUM_EN.
module testbasic0_reader
   import testbasic0_reader_types::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W,
   parameter int DEPTH  = DEFAULT_DEPTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] b_in,
   input  logic              b_in_sync,
   output logic              b_in_notify,
   output logic [DATA_W-1:0] c_out,
   input  logic              c_out_sync,
   output logic              c_out_notify,
   output logic [31:0]       rd_count
`ifdef TESTBASIC0_READER_SUM_EN
   ,
   output logic [DATA_W-1:0] sum_out
`endif
);

   localparam int OCC_W = $clog2(DEPTH) + 1;
   localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

   Sections           section_signal;
   Sections           nextsection_signal;
   logic              push;
   logic              pop;
   logic [OCC_W-1:0]  occ_next;
   logic [DATA_W-1:0] head_next;

   // Notifies decode straight from the section register, so they stay registered.
   assign b_in_notify  = (section_signal != SEC_FULL);
   assign c_out_notify = (section_signal != SEC_IDLE);
   assign push         = b_in_notify && b_in_sync;
   assign pop          = c_out_notify && c_out_sync;

   testbasic0_reader_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .pop       (pop),
      .din       (b_in),
      .occ_next  (occ_next),
      .head_next (head_next)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         section_signal <= SEC_IDLE;
      else
         section_signal <= nextsection_signal;
   end

   always_comb begin
      nextsection_signal = SEC_BUSY;
      if (occ_next == '0)
         nextsection_signal = SEC_IDLE;
      else if (occ_next == FULL_OCC)
         nextsection_signal = SEC_FULL;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         c_out    <= '0;
         rd_count <= '0;
      end else begin
         c_out <= head_next;
         if (push)
            rd_count <= rd_count + 32'd1;
      end
   end

`ifdef TESTBASIC0_READER_SUM_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         sum_out <= '0;
      else if (push)
         sum_out <= sum_out + b_in;
   end
`endif

endmodule

// File: tb/tb_testbasic0_reader.sv
// tb/tb_testbasic0_reader.sv - scoreboard bench for testbasic0_reader (optionally with TESTBASIC0_READER_SUM_EN)
module tb_testbasic0_reader;
   import testbasic0_reader_types::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] b_in = '0;
   logic        b_in_sync = 1'b0;
   logic        b_in_notify;
   logic [31:0] c_out;
   logic        c_out_sync = 1'b0;
   logic        c_out_notify;
   logic [31:0] rd_count;
`ifdef TESTBASIC0_READER_SUM_EN
   logic [31:0] sum_out;
`endif

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   testbasic0_reader #(.DATA_W(32), .DEPTH(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .b_in         (b_in),
      .b_in_sync    (b_in_sync),
      .b_in_notify  (b_in_notify),
      .c_out        (c_out),
      .c_out_sync   (c_out_sync),
      .c_out_notify (c_out_notify),
      .rd_count     (rd_count)
`ifdef TESTBASIC0_READER_SUM_EN
      ,
      .sum_out      (sum_out)
`endif
   );

   // Scoreboard: inputs settle at posedge+1, so the negedge shows what the next posedge transfers.
   always @(negedge clk) begin
      logic [31:0] exp;
      if (!rst) begin
         exp_q.delete();
      end else begin
         if (c_out_notify && c_out_sync) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL scoreboard_underflow: got %0h, required nothing", c_out);
            end else begin
               exp = exp_q.pop_front();
               if (c_out !== exp) begin
                  errors++;
                  $display("FAIL scoreboard_order: got %0h, required %0h", c_out, exp);
               end
            end
         end
         if (b_in_notify && b_in_sync)
            exp_q.push_back(b_in);
      end
   end

   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, got, req);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      b_in = 32'hAA;
      b_in_sync = 1'b1;
      c_out_sync = 1'b1;
      step(3);
      checks++;
      if (b_in_notify !== 1'b1 || c_out_notify !== 1'b0) begin
         errors++;
         $display("FAIL reset_notify: got %b/%b, required 1/0", b_in_notify, c_out_notify);
      end
      chk32("reset_c_out", c_out, 32'h0);
      chk32("reset_rd_count", rd_count, 32'h0);
      checks++;
      if (dut.section_signal !== SEC_IDLE) begin
         errors++;
         $display("FAIL reset_section: got %0d, required %0d", dut.section_signal, SEC_IDLE);
      end
      b_in_sync = 1'b0;
      c_out_sync = 1'b0;
      rst = 1'b1;
      step(1);
      chk32("post_reset_rd_count", rd_count, 32'h0);
   endtask

   task automatic test_fill_three();
      b_in = 32'd1;
      b_in_sync = 1'b1;
      step(1);
      chk32("first_word_c_out", c_out, 32'd1);
      chk32("first_word_notify", {31'd0, c_out_notify}, 32'd1);
      b_in = 32'd2;
      step(1);
      b_in = 32'd3;
      step(1);
      b_in_sync = 1'b0;
      chk32("three_rd_count", rd_count, 32'd3);
      chk32("three_c_out_held", c_out, 32'd1);
      checks++;
      if (dut.section_signal !== SEC_BUSY) begin
         errors++;
         $display("FAIL three_section: got %0d, required %0d", dut.section_signal, SEC_BUSY);
      end
      c_out_sync = 1'b1;
      step(3);
      c_out_sync = 1'b0;
      chk32("three_drained_notify", {31'd0, c_out_notify}, 32'd0);
      step(2);
      chk32("idle_sync_ignored", {31'd0, c_out_notify}, 32'd0);
   endtask

   task automatic test_full();
      logic [31:0] words [5] = '{32'd10, 32'd11, 32'd12, 32'd13, 32'd14};
      b_in_sync = 1'b1;
      for (int i = 0; i < 4; i++) begin
         b_in = words[i];
         step(1);
      end
      chk32("full_b_in_notify", {31'd0, b_in_notify}, 32'd0);
      chk32("full_rd_count", rd_count, 32'd7);
      checks++;
      if (dut.section_signal !== SEC_FULL) begin
         errors++;
         $display("FAIL full_section: got %0d, required %0d", dut.section_signal, SEC_FULL);
      end
      b_in = words[4];
      step(3);
      chk32("full_stall_rd_count", rd_count, 32'd7);
      c_out_sync = 1'b1;
      step(1);
      c_out_sync = 1'b0;
      chk32("pop_from_full_notify", {31'd0, b_in_notify}, 32'd1);
      chk32("pop_from_full_head", c_out, 32'd11);
      step(1);
      b_in_sync = 1'b0;
      chk32("fifth_accepted", rd_count, 32'd8);
      c_out_sync = 1'b1;
      step(4);
      c_out_sync = 1'b0;
      chk32("full_drained_notify", {31'd0, c_out_notify}, 32'd0);
   endtask

   task automatic test_back_to_back();
      b_in = 32'd100;
      b_in_sync = 1'b1;
      step(1);
      c_out_sync = 1'b1;
      for (int i = 0; i < 20; i++) begin
         b_in = 32'd200 + 32'(i);
         step(1);
         chk32("stream_occupancy", 32'(dut.u_fifo.occ), 32'd1);
      end
      b_in_sync = 1'b0;
      step(1);
      c_out_sync = 1'b0;
      chk32("stream_drained_notify", {31'd0, c_out_notify}, 32'd0);
      chk32("stream_rd_count", rd_count, 32'd29);
   endtask

   task automatic test_reset_mid();
      b_in_sync = 1'b1;
      for (int i = 0; i < 3; i++) begin
         b_in = 32'd50 + 32'(i);
         step(1);
      end
      b_in_sync = 1'b0;
      rst = 1'b0;
      #1;
      chk32("mid_reset_notify", {31'd0, c_out_notify}, 32'd0);
      chk32("mid_reset_rd_count", rd_count, 32'd0);
      chk32("mid_reset_c_out", c_out, 32'd0);
      step(2);
      rst = 1'b1;
      step(2);
      chk32("after_reset_still_empty", {31'd0, c_out_notify}, 32'd0);
      b_in = 32'd60;
      b_in_sync = 1'b1;
      step(1);
      b_in_sync = 1'b0;
      chk32("after_reset_new_head", c_out, 32'd60);
      c_out_sync = 1'b1;
      step(1);
      c_out_sync = 1'b0;
      chk32("after_reset_empty_again", {31'd0, c_out_notify}, 32'd0);
   endtask

`ifdef TESTBASIC0_READER_SUM_EN
   task automatic test_sum();
      rst = 1'b0;
      step(1);
      rst = 1'b1;
      step(1);
      b_in_sync = 1'b1;
      b_in = 32'hFFFF_FFFF;
      step(1);
      b_in = 32'd2;
      step(1);
      b_in_sync = 1'b0;
      chk32("sum_wrap", sum_out, 32'd1);
      c_out_sync = 1'b1;
      step(2);
      c_out_sync = 1'b0;
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_fill_three();
      test_full();
      test_back_to_back();
      test_reset_mid();
`ifdef TESTBASIC0_READER_SUM_EN
      test_sum();
`endif
      step(2);
      chk32("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
